// File: rtl/quad_debounce_pkg.sv
// Shared defaults for the quadrature debouncer.
package quad_debounce_pkg;

  // Defaults for the filter window and the synchronizer depth.
  localparam int unsigned QD_STABLE_CYCLES = 16;
  localparam int unsigned QD_SYNC_STAGES   = 2;

  // Number of encoder channels (A and B).
  localparam int unsigned QD_NUM_CH = 2;

endpackage

// File: rtl/quad_debounce_channel.sv
// One debounced bit: input synchronizer, stability counter, output register.
module debounce_channel
  import quad_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = QD_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = QD_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  // Count at which the next mismatching edge adopts the new level.
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   s;

  assign s    = sync_q[SYNC_STAGES-1];
  assign dout = out_q;

  // Shift the raw input through the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  // Any agreement with the output restarts the window; the final count
  // folds into the toggle so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (s == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      out_d = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1'b1);
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

endmodule

// File: rtl/quad_debounce.sv
// Two independent debouncers for the A/B lines of a rotary encoder.
module quad_debounce
  import quad_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = QD_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = QD_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic Ain,
  input  logic Bin,
  output logic Aout,
  output logic Bout
);

  logic [QD_NUM_CH-1:0] din, dout;

  assign din  = {Ain, Bin};
  assign Aout = dout[1];
  assign Bout = dout[0];

  // Identical per-channel filters with no shared state.
  for (genvar g = 0; g < QD_NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din[g]),
      .dout  (dout[g])
    );
  end

endmodule

// File: tb/tb_quad_debounce.sv
// Scoreboard bench: stimulus queues expected output changes, a monitor
// matches every observed change of {Aout,Bout} against the queue.
module tb_quad_debounce;

  typedef struct {
    int   cyc;
    logic a;
    logic b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic Ain, Bin;
  logic Aout, Bout;
  logic A1out, B1out;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t expq[$];
  logic [1:0] prev = 2'b00;

  localparam int LAT = 18;

  quad_debounce dut (
    .clk(clk), .rst_n(rst_n), .Ain(Ain), .Bin(Bin), .Aout(Aout), .Bout(Bout)
  );

  quad_debounce #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Ain(Ain), .Bin(Bin), .Aout(A1out), .Bout(B1out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int dly, input logic a, input logic b);
    exp_t e;
    e.cyc = cyc + dly;
    e.a   = a;
    e.b   = b;
    expq.push_back(e);
  endtask

  // Monitor: every output change must match the head of the queue exactly.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev = 2'b00;
    end else if ({Aout, Bout} != prev) begin
      if (expq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_change: got AB=%b at cycle %0d, expected no change",
                 {Aout, Bout}, cyc);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("change_cycle", cyc, e.cyc);
        chk("change_value", int'({Aout, Bout}), int'({e.a, e.b}));
      end
      prev = {Aout, Bout};
    end
  end

  initial begin
    // Reset with inputs high: outputs must be low at once.
    rst_n = 1'b0;
    Ain   = 1'b1;
    Bin   = 1'b1;
    #1;
    chk("reset_immediate", int'({Aout, Bout}), 0);
    wait_clk(5);
    chk("reset_held", int'({Aout, Bout}), 0);
    rst_n = 1'b1;
    push(LAT, 1'b1, 1'b1);
    wait_clk(100);

    // Clockwise: 11 -> 10 -> 00 -> 01 -> 11.
    begin
      logic [1:0] cw [4];
      cw[0] = 2'b10; cw[1] = 2'b00; cw[2] = 2'b01; cw[3] = 2'b11;
      for (int i = 0; i < 4; i++) begin
        {Ain, Bin} = cw[i];
        push(LAT, cw[i][1], cw[i][0]);
        wait_clk(100);
      end
    end

    // Counter-clockwise: 11 -> 01 -> 00 -> 10 -> 11.
    begin
      logic [1:0] ccw [4];
      ccw[0] = 2'b01; ccw[1] = 2'b00; ccw[2] = 2'b10; ccw[3] = 2'b11;
      for (int i = 0; i < 4; i++) begin
        {Ain, Bin} = ccw[i];
        push(LAT, ccw[i][1], ccw[i][0]);
        wait_clk(100);
      end
    end

    // Both channels drop together: outputs fall on the same edge.
    {Ain, Bin} = 2'b00;
    push(LAT, 1'b0, 1'b0);
    wait_clk(100);

    // Bounce on A: five 3-clock pulses with 3-clock lows, then steady high.
    for (int i = 0; i < 5; i++) begin
      Ain = 1'b1; wait_clk(3);
      Ain = 1'b0; wait_clk(3);
    end
    Ain = 1'b1;
    push(LAT, 1'b1, 1'b0);
    wait_clk(100);
    Ain = 1'b0;
    push(LAT, 1'b0, 1'b0);
    wait_clk(100);

    // B pulse one clock too short: rejected.
    Bin = 1'b1; wait_clk(15);
    Bin = 1'b0; wait_clk(100);

    // B pulse of exactly the window: passes, high for 16 clocks.
    Bin = 1'b1;
    push(LAT, 1'b0, 1'b1);
    wait_clk(2);
    chk("w1_before", int'({A1out, B1out}), 0);
    wait_clk(1);
    chk("w1_after", int'({A1out, B1out}), 1);
    wait_clk(13);
    Bin = 1'b0;
    push(LAT, 1'b0, 1'b0);
    wait_clk(100);

    // Mid-count reset: B is high at the output, A is counting.
    Bin = 1'b1;
    push(LAT, 1'b0, 1'b1);
    wait_clk(100);
    Ain = 1'b1;
    wait_clk(10);
    rst_n = 1'b0;
    #1;
    chk("midreset_immediate", int'({Aout, Bout}), 0);
    wait_clk(3);
    chk("midreset_held", int'({Aout, Bout}), 0);
    rst_n = 1'b1;
    push(LAT, 1'b1, 1'b1);
    wait_clk(100);

    // Every queued change must have been seen.
    chk("pending_expectations", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
